// File: rtl/rv32i_enc_pkg.sv
// Shared RV32I encoder definitions: instruction class codes, major opcodes,
// the class-to-opcode mapping and the stage-1 request record.
// Also used by the decoder regression bench.
package rv32i_enc_pkg;

  typedef enum logic [3:0] {
    CLS_R     = 4'd0,
    CLS_I_L   = 4'd1,
    CLS_I_C   = 4'd2,
    CLS_JALR  = 4'd3,
    CLS_S     = 4'd4,
    CLS_B     = 4'd5,
    CLS_LUI   = 4'd6,
    CLS_AUIPC = 4'd7,
    CLS_JAL   = 4'd8
  } enc_class_e;

  localparam logic [3:0] CLS_LAST = 4'd8;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I_L   = 7'b0000011;
  localparam logic [6:0] OP_I_C   = 7'b0010011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  // Request fields captured in stage 1, opcode already resolved.
  typedef struct packed {
    logic [3:0]  cls;
    logic [2:0]  funct3;
    logic        f7b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [6:0]  opcode;
  } s1_req_t;

  // Illegal classes map to an all-zero opcode; the word is zeroed later anyway.
  function automatic logic [6:0] class_opcode(input logic [3:0] cls);
    case (cls)
      CLS_R:     return OP_R;
      CLS_I_L:   return OP_I_L;
      CLS_I_C:   return OP_I_C;
      CLS_JALR:  return OP_JALR;
      CLS_S:     return OP_S;
      CLS_B:     return OP_B;
      CLS_LUI:   return OP_LUI;
      CLS_AUIPC: return OP_AUIPC;
      CLS_JAL:   return OP_JAL;
      default:   return 7'b0000000;
    endcase
  endfunction

  function automatic logic class_legal(input logic [3:0] cls);
    return cls <= CLS_LAST;
  endfunction

endpackage

// File: rtl/rv32i_imm_packer.sv
// Combinational immediate placement for every RV32I format. imm_bits holds
// only the immediate-derived bits in their final instruction positions
// (plus the funct7 bit of immediate shifts); all other bits are 0.
// Optional build macro ENC_RANGE_CHECK_EN enables the immediate range check;
// without it range_err is tied low and out-of-range values truncate.
module rv32i_imm_packer
  import rv32i_enc_pkg::*;
(
  input  logic [3:0]  cls,
  input  logic [2:0]  funct3,
  input  logic        f7b5,
  input  logic [31:0] imm,
  output logic [31:0] imm_bits,
  output logic        range_err
);

  logic is_shift;

  assign is_shift = (cls == CLS_I_C) && ((funct3 == 3'b001) || (funct3 == 3'b101));

  // Scatter immediate bits into the field layout of the selected format.
  always_comb begin
    imm_bits = '0;
    case (cls)
      CLS_I_L, CLS_JALR: imm_bits = {imm[11:0], 20'b0};
      CLS_I_C: begin
        if (is_shift) imm_bits = {1'b0, f7b5, 5'b0, imm[4:0], 20'b0};
        else          imm_bits = {imm[11:0], 20'b0};
      end
      CLS_S:             imm_bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
      CLS_B:             imm_bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
      CLS_LUI, CLS_AUIPC: imm_bits = {imm[31:12], 12'b0};
      CLS_JAL:           imm_bits = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
      default:           imm_bits = '0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  // A signed value fits in N bits when every bit from N-1 upward matches.
  logic fits12, fits13, fits21;

  assign fits12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21 = (&imm[31:20]) | ~(|imm[31:20]);

  // Flag immediates that cannot be represented without truncation.
  always_comb begin
    range_err = 1'b0;
    case (cls)
      CLS_I_L, CLS_JALR, CLS_S: range_err = ~fits12;
      CLS_I_C: begin
        if (is_shift) range_err = |imm[31:5];
        else          range_err = ~fits12;
      end
      CLS_B:              range_err = ~fits13 | imm[0];
      CLS_JAL:            range_err = ~fits21 | imm[0];
      CLS_LUI, CLS_AUIPC: range_err = |imm[11:0];
      default:            range_err = 1'b0;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

endmodule

// File: rtl/rv32i_inst_encoder.sv
// RV32I instruction encoder: class + operand fields -> 32-bit instruction.
// Two-stage valid/ready pipeline, one word per cycle, at most two in flight.
// Stage 1 registers the request and resolves the opcode; stage 2 packs the
// word and flags illegal classes. Build macro ENC_RANGE_CHECK_EN (in
// rv32i_imm_packer) additionally turns unrepresentable immediates into errors.
module rv32i_inst_encoder
  import rv32i_enc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_class,
  input  logic [2:0]  in_funct3,
  input  logic        in_f7b5,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err
);

  s1_req_t     s1_q;
  logic        s1_valid;
  logic        s2_load;
  logic        s1_advance;
  logic        in_fire;
  logic [31:0] imm_bits;
  logic        range_err;
  logic [31:0] word;
  logic        err_next;
  logic [31:0] instr_next;

  // Stage 2 refills when empty or when its word leaves this cycle.
  assign s2_load    = ~out_valid | out_ready;
  assign s1_advance = s1_valid & s2_load;
  assign in_ready   = ~s1_valid | s1_advance;
  assign in_fire    = in_valid & in_ready;

  // Stage 1: capture the request and resolve its opcode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_q     <= '0;
    end else if (in_fire) begin
      s1_valid      <= 1'b1;
      s1_q.cls      <= in_class;
      s1_q.funct3   <= in_funct3;
      s1_q.f7b5     <= in_f7b5;
      s1_q.rd       <= in_rd;
      s1_q.rs1      <= in_rs1;
      s1_q.rs2      <= in_rs2;
      s1_q.imm      <= in_imm;
      s1_q.opcode   <= class_opcode(in_class);
    end else if (s1_advance) begin
      s1_valid <= 1'b0;
    end
  end

  rv32i_imm_packer u_imm_packer (
    .cls       (s1_q.cls),
    .funct3    (s1_q.funct3),
    .f7b5      (s1_q.f7b5),
    .imm       (s1_q.imm),
    .imm_bits  (imm_bits),
    .range_err (range_err)
  );

  // Merge register fields, funct3 and opcode with the placed immediate.
  always_comb begin
    word = '0;
    case (s1_q.cls)
      CLS_R:
        word = {1'b0, s1_q.f7b5, 5'b0, s1_q.rs2, s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
      CLS_I_L, CLS_I_C:
        word = imm_bits | {12'b0, s1_q.rs1, s1_q.funct3, s1_q.rd, s1_q.opcode};
      CLS_JALR:
        word = imm_bits | {12'b0, s1_q.rs1, 3'b000, s1_q.rd, s1_q.opcode};
      CLS_S, CLS_B:
        word = imm_bits | {7'b0, s1_q.rs2, s1_q.rs1, s1_q.funct3, 5'b0, s1_q.opcode};
      CLS_LUI, CLS_AUIPC, CLS_JAL:
        word = imm_bits | {20'b0, s1_q.rd, s1_q.opcode};
      default:
        word = '0;
    endcase
  end

  // An erroneous request still produces a word, but always an all-zero one.
  assign err_next   = ~class_legal(s1_q.cls) | range_err;
  assign instr_next = err_next ? 32'h0 : word;

  // Stage 2: output register; holds steady while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_err   <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_instr <= instr_next;
        out_err   <= err_next;
      end
    end
  end

endmodule

// File: tb/tb_rv32i_inst_encoder.sv
// Scoreboard bench for rv32i_inst_encoder: directed words from hand-encoded
// constants, then randomized requests against a reference encoder.
// Follows ENC_RANGE_CHECK_EN to choose the expected error behaviour.
module tb_rv32i_inst_encoder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_class;
  logic [2:0]  in_funct3;
  logic        in_f7b5;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  rv32i_inst_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_class  (in_class),
    .in_funct3 (in_funct3),
    .in_f7b5   (in_f7b5),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_err   (out_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int n_out = 0;

  logic [32:0] exp_q[$];

  logic        drv_lit = 1'b0;
  logic [31:0] drv_lit_instr = '0;
  logic        drv_lit_err = 1'b0;
  logic        rnd_bp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built straight from the format tables.
  function automatic void model(input logic [3:0] c, input logic [2:0] f3, input logic f7,
                                input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [31:0] imm, output logic [31:0] ins, output logic e);
    logic [31:0] opc_tab[9];
    logic [31:0] op, r_d, r_s1, r_s2, f_3, field;
    int signed si;
    logic rng_bad;
    opc_tab = '{32'h33, 32'h03, 32'h13, 32'h67, 32'h23, 32'h63, 32'h37, 32'h17, 32'h6F};
    si = imm;
    e = 1'b0;
    ins = '0;
    rng_bad = 1'b0;
    if (c > 4'd8) begin
      e = 1'b1;
      return;
    end
    op   = opc_tab[c];
    r_d  = 32'(rd) << 7;
    r_s1 = 32'(rs1) << 15;
    r_s2 = 32'(rs2) << 20;
    f_3  = 32'(f3) << 12;
    case (c)
      4'd0: ins = (32'(f7) << 30) | r_s2 | r_s1 | f_3 | r_d | op;
      4'd1, 4'd2, 4'd3: begin
        if (c == 4'd2 && (f3 == 3'd1 || f3 == 3'd5)) begin
          field = (32'(f7) << 10) | (imm & 32'd31);
          rng_bad = (si < 0) || (si > 31);
        end else begin
          field = imm & 32'hFFF;
          rng_bad = (si < -2048) || (si > 2047);
        end
        if (c == 4'd3) f_3 = 0;
        ins = (field << 20) | r_s1 | f_3 | r_d | op;
      end
      4'd4: begin
        ins = (((imm >> 5) & 32'd127) << 25) | r_s2 | r_s1 | f_3 | ((imm & 32'd31) << 7) | op;
        rng_bad = (si < -2048) || (si > 2047);
      end
      4'd5: begin
        ins = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25) | r_s2 | r_s1 | f_3
            | (((imm >> 1) & 32'd15) << 8) | (((imm >> 11) & 32'd1) << 7) | op;
        rng_bad = (si < -4096) || (si > 4094) || (imm[0] == 1'b1);
      end
      4'd6, 4'd7: begin
        ins = (imm & 32'hFFFFF000) | r_d | op;
        rng_bad = (imm & 32'hFFF) != 0;
      end
      default: begin
        ins = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'd1023) << 21)
            | (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'd255) << 12) | r_d | op;
        rng_bad = (si < -1048576) || (si > 1048574) || (imm[0] == 1'b1);
      end
    endcase
`ifdef ENC_RANGE_CHECK_EN
    if (rng_bad) begin
      ins = '0;
      e = 1'b1;
    end
`endif
  endfunction

  // Accept side: the transfer happens on the coming rising edge.
  always @(negedge clk) begin
    logic [31:0] ei;
    logic ee;
    if (!rst && in_valid && in_ready) begin
      if (drv_lit) begin
        ei = drv_lit_instr;
        ee = drv_lit_err;
      end else begin
        model(in_class, in_funct3, in_f7b5, in_rd, in_rs1, in_rs2, in_imm, ei, ee);
      end
      exp_q.push_back({ee, ei});
    end
  end

  // Monitor: checks every output transfer and stability under stall.
  logic        hold_chk = 1'b0;
  logic [31:0] hold_instr;
  logic        hold_err;
  always @(negedge clk) begin
    logic [32:0] e;
    if (rst) begin
      hold_chk = 1'b0;
    end else begin
      if (hold_chk) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_instr", out_instr, hold_instr);
        chk("stall_err", 32'(out_err), 32'(hold_err));
      end
      if (out_valid && out_ready) begin
        n_out++;
        chk("unexpected_word", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("out_instr", out_instr, e[31:0]);
          chk("out_err", 32'(out_err), 32'(e[32]));
        end
      end
      hold_chk   = out_valid && !out_ready;
      hold_instr = out_instr;
      hold_err   = out_err;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic set_req(input int c, input int f3, input int f7, input int rd,
                         input int rs1, input int rs2, input logic [31:0] imm);
    in_class  = 4'(c);
    in_funct3 = 3'(f3);
    in_f7b5   = 1'(f7);
    in_rd     = 5'(rd);
    in_rs1    = 5'(rs1);
    in_rs2    = 5'(rs2);
    in_imm    = imm;
  endtask

  task automatic send(input int c, input int f3, input int f7, input int rd,
                      input int rs1, input int rs2, input logic [31:0] imm);
    logic ok;
    ok = 1'b0;
    set_req(c, f3, f7, rd, rs1, rs2, imm);
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL send_timeout: request not accepted within 200 cycles");
    end
  endtask

  task automatic send_lit(input int c, input int f3, input int f7, input int rd,
                          input int rs1, input int rs2, input logic [31:0] imm,
                          input logic [31:0] ei, input logic ee);
    drv_lit       = 1'b1;
    drv_lit_instr = ei;
    drv_lit_err   = ee;
    send(c, f3, f7, rd, rs1, rs2, imm);
    drv_lit = 1'b0;
  endtask

  task automatic drain();
    for (int n = 0; n < 200; n++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    chk("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int base;
    logic ok;
    logic [3:0] rc;
    logic [31:0] ri;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_req(0, 0, 0, 0, 0, 0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ADD x3,x1,x2 with a latency probe on an empty pipeline.
    send_lit(0, 0, 0, 3, 1, 2, 32'h0, 32'h002081B3, 1'b0);
    chk("latency_c1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("latency_c2", 32'(out_valid), 32'd1);
    drain();

    send_lit(0, 0, 1, 3, 1, 2, 32'h0, 32'h402081B3, 1'b0);
    send_lit(2, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 32'hFFF00093, 1'b0);
    send_lit(4, 2, 0, 0, 1, 2, 32'd8, 32'h0020A423, 1'b0);
    send_lit(5, 0, 0, 0, 1, 2, 32'hFFFFFFFC, 32'hFE208EE3, 1'b0);
    send_lit(8, 0, 0, 1, 0, 0, 32'd2048, 32'h001000EF, 1'b0);
    drain();

    base = n_out;
    send_lit(12, 0, 0, 5, 6, 7, 32'h123, 32'h0, 1'b1);
    drain();
    chk("illegal_slots", 32'(n_out - base), 32'd1);

`ifdef ENC_RANGE_CHECK_EN
    send_lit(2, 0, 0, 0, 0, 0, 32'd2048, 32'h0, 1'b1);
`else
    send_lit(2, 0, 0, 0, 0, 0, 32'd2048, 32'h80000013, 1'b0);
`endif
    drain();

    // Backpressure: three back-to-back requests against a stalled consumer.
    base = n_out;
    out_ready = 1'b0;
    acc = 0;
    set_req(0, 0, 0, 10, 11, 12, 32'h0);
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        acc++;
        set_req(0, 0, 0, 10 + acc, 11, 12, 32'h0);
      end
    end
    chk("bp_accepts", 32'(acc), 32'd2);
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) break;
    end
    in_valid = 1'b0;
    chk("bp_third_accept", 32'(ok), 32'd1);
    drain();
    chk("bp_word_count", 32'(n_out - base), 32'd3);

    // Reset with two words in flight.
    out_ready = 1'b0;
    send(6, 0, 0, 1, 0, 0, 32'h12345000);
    send(7, 0, 0, 2, 0, 0, 32'hABCDE000);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Randomized traffic with random consumer stalls.
    rnd_bp = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) == 0) rc = 4'($urandom_range(9, 15));
      else                           rc = 4'($urandom_range(0, 8));
      case ($urandom_range(0, 4))
        0: ri = $urandom;
        1: ri = 32'($urandom_range(0, 8191)) - 32'd4096;
        2: ri = 32'($urandom_range(0, 63)) - 32'd16;
        3: ri = $urandom & 32'hFFFFF000;
        default: ri = (32'($urandom_range(0, 2097151)) - 32'd1048576) & ~32'd1;
      endcase
      send(int'(rc), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
           int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
           int'($urandom_range(0, 31)), ri);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_bp = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
